wash_phase_timer: RTL

- Timing controller for the washing-machine sequencer FSM.
- Generates the cycle_timeout and spin_timeout handshakes that the FSM waits on; a later tie-off change removes them as testbench inputs.
- Wash and spin durations come from a selectable program.
- Includes a tick prescaler, pause/freeze and a remaining-time readout for the front panel.

---
 rtl/wash_phase_timer_if.sv | 25 ++
 rtl/wash_phase_timer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/wash_phase_timer_if.sv
// Handshake bundle between the washer sequencer FSM and its phase timer.
// The program select is named program_sel because "program" is a reserved word.
interface wash_phase_timer_if #(
   parameter int CNT_W = 12
);
   logic             cycle_run;
   logic             spin_run;
   logic [1:0]       program_sel;
   logic             pause;
   logic             cycle_timeout;
   logic             spin_timeout;
   logic             busy;
   logic [1:0]       phase;
   logic [CNT_W-1:0] remaining;

   modport master (
      output cycle_run, spin_run, program_sel, pause,
      input  cycle_timeout, spin_timeout, busy, phase, remaining
   );

   modport slave (
      input  cycle_run, spin_run, program_sel, pause,
      output cycle_timeout, spin_timeout, busy, phase, remaining
   );
endinterface

// File: rtl/wash_phase_timer.sv
// Wash/spin phase timer: prescaled tick countdown per program, pause freeze,
// and level timeouts held until the sequencer drops the matching run input.
module wash_phase_timer #(
   parameter int TICK_DIV    = 1000,
   parameter int CNT_W       = 12,
   parameter int WASH_SHORT  = 30,
   parameter int WASH_NORMAL = 60,
   parameter int WASH_HEAVY  = 90,
   parameter int SPIN_SHORT  = 10,
   parameter int SPIN_NORMAL = 20,
   parameter int SPIN_HEAVY  = 30
) (
   input  logic                clk,
   input  logic                reset,
   wash_phase_timer_if.slave   bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, CYCLE, CYC_EXP, SPIN, SPN_EXP} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [1:0]       prog_q, prog_d;
   logic             cto_q, cto_d;
   logic             sto_q, sto_d;
   logic             busy_q, busy_d;
   logic [1:0]       phase_q, phase_d;
   logic             tick;
   logic             run;

   function automatic logic [CNT_W-1:0] wash_ticks(input logic [1:0] p);
      case (p)
         2'd0:    return CNT_W'(WASH_SHORT);
         2'd2:    return CNT_W'(WASH_HEAVY);
         default: return CNT_W'(WASH_NORMAL);
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] spin_ticks(input logic [1:0] p);
      case (p)
         2'd0:    return CNT_W'(SPIN_SHORT);
         2'd2:    return CNT_W'(SPIN_HEAVY);
         default: return CNT_W'(SPIN_NORMAL);
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      rem_d   = rem_q;
      prog_d  = prog_q;
      tick    = (presc_q == PW'(TICK_DIV - 1)) && !bus.pause;
      // The run input that owns the current phase; the other one is ignored.
      run     = (state_q == CYCLE || state_q == CYC_EXP) ? bus.cycle_run : bus.spin_run;
      unique case (state_q)
         IDLE: begin
            rem_d   = '0;
            presc_d = '0;
            if (bus.cycle_run) begin
               state_d = CYCLE;
               prog_d  = bus.program_sel;
               rem_d   = wash_ticks(bus.program_sel);
            end else if (bus.spin_run) begin
               state_d = SPIN;
               prog_d  = bus.program_sel;
               rem_d   = spin_ticks(bus.program_sel);
            end
         end
         CYCLE, SPIN: begin
            if (!run) begin
               state_d = IDLE;
               rem_d   = '0;
               presc_d = '0;
            end else if (rem_q == '0) begin
               // Zero-length phase expires on the first edge, paused or not.
               state_d = (state_q == CYCLE) ? CYC_EXP : SPN_EXP;
            end else if (!bus.pause) begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  rem_d = rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1))
                     state_d = (state_q == CYCLE) ? CYC_EXP : SPN_EXP;
               end
            end
         end
         CYC_EXP, SPN_EXP: begin
            if (!run) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      cto_d   = (state_d == CYC_EXP);
      sto_d   = (state_d == SPN_EXP);
      busy_d  = (state_d == CYCLE) || (state_d == SPIN);
      phase_d = (state_d == CYCLE || state_d == CYC_EXP) ? 2'd1 :
                (state_d == SPIN  || state_d == SPN_EXP) ? 2'd2 : 2'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         rem_q   <= '0;
         prog_q  <= '0;
         cto_q   <= 1'b0;
         sto_q   <= 1'b0;
         busy_q  <= 1'b0;
         phase_q <= 2'd0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         rem_q   <= rem_d;
         prog_q  <= prog_d;
         cto_q   <= cto_d;
         sto_q   <= sto_d;
         busy_q  <= busy_d;
         phase_q <= phase_d;
      end
   end

   assign bus.cycle_timeout = cto_q;
   assign bus.spin_timeout  = sto_q;
   assign bus.busy          = busy_q;
   assign bus.phase         = phase_q;
   assign bus.remaining     = rem_q;
endmodule
